// File: rtl/prbs_channel_tx_pkg.sv
// Shared constants for the PRBS9 BPSK transmitter and ISI channel model.
package prbs_channel_tx_pkg;

    localparam logic [8:0]        PRBS9_SEED  = 9'h1FF;
    localparam int                PRBS9_TAP_A = 8;
    localparam int                PRBS9_TAP_B = 4;

    // Bit value carried for each BPSK symbol; sign bit 1 means -1 at the slicer.
    localparam logic              SYM_BIT_POS = 1'b0;
    localparam logic              SYM_BIT_NEG = 1'b1;

    localparam int                SAT_HI_DEF  = 1023;
    localparam int                SAT_LO_DEF  = -1024;

    localparam logic signed [7:0] TAP_IMPULSE = 8'sh7F;

    function automatic int sat_hi(input int bw);
        return (1 << (bw - 1)) - 1;
    endfunction

    function automatic int sat_lo(input int bw);
        return -(1 << (bw - 1));
    endfunction

endpackage

// File: rtl/prbs_channel_tx_prbs9_gen.sv
// PRBS9 (x^9 + x^5 + 1) Fibonacci generator; o_b is the current symbol bit.
module prbs9_gen
    import prbs_channel_tx_pkg::*;
(
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_en,
    output logic o_b
);

    logic [8:0] state_q;

    assign o_b = state_q[PRBS9_TAP_A] ^ state_q[PRBS9_TAP_B];

    // State shift on each symbol enable, reseeded on reset.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q <= PRBS9_SEED;
        end else if (i_en) begin
            state_q <= {state_q[7:0], o_b};
        end
    end

endmodule

// File: rtl/prbs_channel_tx.sv
// PRBS9 BPSK source driven through a programmable ISI FIR with saturating
// output, plus shadow/active tap banks loaded through a commit handshake.
module prbs_channel_tx
    import prbs_channel_tx_pkg::*;
#(
    parameter int N_TAP  = 3,
    parameter int TAP_BW = 8,
    parameter int OUT_BW = 11,
    parameter int CNT_BW = 16
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_en,
    input  logic                     i_coef_wr,
    input  logic [2:0]               i_coef_addr,
    input  logic signed [TAP_BW-1:0] i_coef_data,
    input  logic                     i_coef_commit,
    output logic signed [OUT_BW-1:0] o_data,
    output logic                     o_bit,
    output logic                     o_valid,
    output logic [CNT_BW-1:0]        o_sym_cnt
);

    // Extra headroom so N_TAP full-scale terms can never wrap before saturation.
    localparam int SUM_BW = OUT_BW + 1 + $clog2(N_TAP);
    localparam int DL_W   = (N_TAP > 1) ? N_TAP - 1 : 1;
    localparam logic signed [SUM_BW-1:0] SAT_HI_S = SUM_BW'(sat_hi(OUT_BW));
    localparam logic signed [SUM_BW-1:0] SAT_LO_S = SUM_BW'(sat_lo(OUT_BW));

    logic                     b_s;
    logic [DL_W-1:0]          dl_q;
    logic [DL_W-1:0]          dl_d;
    logic [N_TAP-1:0]         win_s;
    logic signed [TAP_BW-1:0] shadow_q   [N_TAP];
    logic signed [TAP_BW-1:0] shadow_d   [N_TAP];
    logic signed [TAP_BW-1:0] active_q   [N_TAP];
    logic signed [TAP_BW-1:0] impulse_s  [N_TAP];
    logic signed [SUM_BW-1:0] acc_s;
    logic signed [OUT_BW-1:0] y_s;
    logic signed [OUT_BW-1:0] data_q;
    logic                     bit_q;
    logic                     valid_q;
    logic [CNT_BW-1:0]        cnt_q;

    prbs9_gen u_prbs9 (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_en    (i_en),
        .o_b     (b_s)
    );

    generate
        if (N_TAP > 1) begin : g_dl
            assign win_s = {dl_q, b_s};
            assign dl_d  = win_s[N_TAP-2:0];
        end else begin : g_no_dl
            assign win_s = b_s;
            assign dl_d  = dl_q;
        end
    endgenerate

    // Reset bank and shadow bank with the pending write merged in.
    always_comb begin
        for (int k = 0; k < N_TAP; k++) begin
            if (k == 0) begin
                impulse_s[k] = TAP_BW'(TAP_IMPULSE);
            end else begin
                impulse_s[k] = '0;
            end
            if (i_coef_wr && (i_coef_addr == 3'(k))) begin
                shadow_d[k] = i_coef_data;
            end else begin
                shadow_d[k] = shadow_q[k];
            end
        end
    end

    // Channel FIR over {current symbol, delay line} and output saturation.
    always_comb begin
        acc_s = '0;
        for (int k = 0; k < N_TAP; k++) begin
            if (win_s[k] == SYM_BIT_NEG) begin
                acc_s = acc_s - {{(SUM_BW-TAP_BW){active_q[k][TAP_BW-1]}}, active_q[k]};
            end else begin
                acc_s = acc_s + {{(SUM_BW-TAP_BW){active_q[k][TAP_BW-1]}}, active_q[k]};
            end
        end
        if (acc_s > SAT_HI_S) begin
            y_s = SAT_HI_S[OUT_BW-1:0];
        end else if (acc_s < SAT_LO_S) begin
            y_s = SAT_LO_S[OUT_BW-1:0];
        end else begin
            y_s = acc_s[OUT_BW-1:0];
        end
    end

    // Tap banks, delay line, registered outputs and symbol counter.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            shadow_q <= impulse_s;
            active_q <= impulse_s;
            dl_q     <= {DL_W{SYM_BIT_POS}};
            data_q   <= '0;
            bit_q    <= 1'b0;
            valid_q  <= 1'b0;
            cnt_q    <= '0;
        end else begin
            shadow_q <= shadow_d;
            if (i_coef_commit) begin
                active_q <= shadow_d;
            end
            if (i_en) begin
                dl_q    <= dl_d;
                data_q  <= y_s;
                bit_q   <= b_s;
                valid_q <= 1'b1;
                cnt_q   <= cnt_q + {{(CNT_BW-1){1'b0}}, 1'b1};
            end else begin
                valid_q <= 1'b0;
            end
        end
    end

    assign o_data    = data_q;
    assign o_bit     = bit_q;
    assign o_valid   = valid_q;
    assign o_sym_cnt = cnt_q;

endmodule

// File: tb/tb_prbs_channel_tx.sv
// Directed bench for prbs_channel_tx: a 3-tap instance and an 8-tap instance
// loaded with all -128 taps to exercise exact -1024 and +1023 saturation.
module tb_prbs_channel_tx;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, en;
    logic        c3_wr, c3_commit, c8_wr, c8_commit;
    logic [2:0]  c3_addr, c8_addr;
    logic [7:0]  c3_data, c8_data;
    logic [10:0] d3, d8;
    logic        b3, b8, v3, v8;
    logic [15:0] n3, n8;

    prbs_channel_tx #(.N_TAP(3), .TAP_BW(8), .OUT_BW(11), .CNT_BW(16)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_en(en),
        .i_coef_wr(c3_wr), .i_coef_addr(c3_addr), .i_coef_data(c3_data),
        .i_coef_commit(c3_commit),
        .o_data(d3), .o_bit(b3), .o_valid(v3), .o_sym_cnt(n3)
    );

    prbs_channel_tx #(.N_TAP(8), .TAP_BW(8), .OUT_BW(11), .CNT_BW(16)) dut8 (
        .i_clk(clk), .i_rst_n(rst_n), .i_en(en),
        .i_coef_wr(c8_wr), .i_coef_addr(c8_addr), .i_coef_data(c8_data),
        .i_coef_commit(c8_commit),
        .o_data(d8), .o_bit(b8), .o_valid(v8), .o_sym_cnt(n8)
    );

    int         checks = 0;
    int         errors = 0;
    logic [8:0] m_s;
    logic [7:0] m_h;
    int         tap3 [3];
    int         m_cnt;
    int         sat_seen = 0;
    bit         chk8;
    logic       exp_b;
    int         exp3, exp8;
    logic [7:0] wv [3];

    task automatic chk(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int sat11(input int v);
        if (v > 1023) return 1023;
        if (v < -1024) return -1024;
        return v;
    endfunction

    task automatic model_reset();
        m_s   = 9'h1FF;
        m_h   = 8'h00;
        tap3  = '{127, 0, 0};
        m_cnt = 0;
    endtask

    // Reference: next PRBS bit, 3-tap channel and 8-tap all -128 channel.
    task automatic model_next();
        int   s3, s8;
        logic w;
        exp_b = m_s[8] ^ m_s[4];
        s3 = 0;
        s8 = 0;
        for (int k = 0; k < 8; k++) begin
            if (k == 0) w = exp_b;
            else        w = m_h[k-1];
            if (k < 3) s3 += w ? -tap3[k] : tap3[k];
            s8 += w ? 128 : -128;
        end
        exp3 = sat11(s3);
        exp8 = sat11(s8);
        if (exp8 == 1023) sat_seen++;
        m_h = {m_h[6:0], exp_b};
        m_s = {m_s[7:0], exp_b};
        m_cnt++;
    endtask

    task automatic do_sym();
        en = 1'b1;
        model_next();
        tick();
        chk("valid", 32'(v3), 1);
        chk("bit", 32'(b3), 32'(exp_b));
        chk("data", 32'($signed(d3)), exp3);
        chk("cnt", 32'(n3), m_cnt);
        if (chk8) begin
            chk("bit8", 32'(b8), 32'(exp_b));
            chk("data8", 32'($signed(d8)), exp8);
        end
    endtask

    task automatic idle_chk();
        en = 1'b0;
        tick();
        chk("gap_valid", 32'(v3), 0);
        chk("gap_data", 32'($signed(d3)), exp3);
        chk("gap_bit", 32'(b3), 32'(exp_b));
        chk("gap_cnt", 32'(n3), m_cnt);
    endtask

    task automatic chk_reset3(input string tag);
        chk({tag, "_data"}, 32'($signed(d3)), 0);
        chk({tag, "_bit"}, 32'(b3), 0);
        chk({tag, "_valid"}, 32'(v3), 0);
        chk({tag, "_cnt"}, 32'(n3), 0);
    endtask

    initial begin
        wv = '{8'h40, 8'h20, 8'hF0};
        rst_n = 1'b0; en = 1'b0; chk8 = 1'b0;
        c3_wr = 1'b0; c3_commit = 1'b0; c3_addr = 3'd0; c3_data = 8'h00;
        c8_wr = 1'b0; c8_commit = 1'b0; c8_addr = 3'd0; c8_data = 8'h00;
        tick();
        tick();
        chk_reset3("rst");
        chk("rst_data8", 32'($signed(d8)), 0);
        chk("rst_valid8", 32'(v8), 0);
        chk("rst_cnt8", 32'(n8), 0);
        rst_n = 1'b1;
        model_reset();
        chk8 = 1'b1;

        // 8-tap bank all -128; 3-tap shadow gets {64,32,-16} but is never committed.
        for (int k = 0; k < 8; k++) begin
            c8_wr = 1'b1; c8_addr = 3'(k); c8_data = 8'h80;
            c3_wr = (k < 3); c3_addr = 3'(k); c3_data = wv[k % 3];
            tick();
            chk("idle_valid", 32'(v3), 0);
        end
        c3_wr = 1'b0; c8_wr = 1'b0;
        c8_commit = 1'b1;
        tick();
        c8_commit = 1'b0;

        for (int i = 0; i < 6; i++) begin
            do_sym();
            chk("open_bit", 32'(b3), (i == 5) ? 1 : 0);
            chk("open_data", 32'($signed(d3)), (i == 5) ? -127 : 127);
            if (i == 0) chk("first8_exact", 32'($signed(d8)), -1024);
        end
        chk("open_cnt", 32'(n3), 6);
        while (m_cnt < 1022) do_sym();
        chk("cnt1022", 32'(n3), 1022);
        chk("sat_seen", 32'(sat_seen > 0), 1);

        // 1-on/3-off enable continues the same sequence.
        for (int i = 0; i < 20; i++) begin
            do_sym();
            idle_chk();
            idle_chk();
            idle_chk();
        end
        chk("gap_total_cnt", 32'(n3), 1042);

        chk8 = 1'b0;
        en = 1'b0;
        rst_n = 1'b0;
        tick();
        chk_reset3("rst2");
        rst_n = 1'b1;
        model_reset();
        for (int k = 0; k < 3; k++) begin
            c3_wr = 1'b1; c3_addr = 3'(k); c3_data = wv[k];
            tick();
        end
        c3_addr = 3'd5; c3_data = 8'h55;
        tick();
        c3_wr = 1'b0;
        c3_commit = 1'b1;
        tick();
        c3_commit = 1'b0;
        tap3 = '{64, 32, -16};
        do_sym();
        chk("commit_80", 32'($signed(d3)), 80);

        en = 1'b0;
        c3_wr = 1'b1; c3_addr = 3'd2; c3_data = 8'h10; c3_commit = 1'b1;
        tick();
        c3_wr = 1'b0; c3_commit = 1'b0;
        tap3[2] = 16;
        do_sym();
        chk("wr_commit_112", 32'($signed(d3)), 112);

        c3_wr = 1'b1; c3_addr = 3'd1; c3_data = 8'h00; c3_commit = 1'b1;
        do_sym();
        c3_wr = 1'b0; c3_commit = 1'b0;
        chk("commit_en_old", 32'($signed(d3)), 112);
        tap3[1] = 0;
        do_sym();
        chk("new_taps_80", 32'($signed(d3)), 80);

        while (m_cnt < 100) do_sym();
        en = 1'b0;
        rst_n = 1'b0;
        tick();
        chk_reset3("rst3");
        rst_n = 1'b1;
        model_reset();
        c3_commit = 1'b1;
        tick();
        c3_commit = 1'b0;
        for (int i = 0; i < 6; i++) begin
            do_sym();
            chk("re_bit", 32'(b3), (i == 5) ? 1 : 0);
            chk("re_data", 32'($signed(d3)), (i == 5) ? -127 : 127);
        end
        chk("re_cnt", 32'(n3), 6);
        en = 1'b0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
